nios_system_edge_pio: RTL and testbench

NIOS_SYSTEM_EDGE_PIO -- requirements
Module: nios_system_edge_pio

---
 rtl/nios_system_edge_pio.sv | 146 ++++++++++++++
 tb/tb_nios_system_edge_pio.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_edge_pio.sv
// nios_system_edge_pio
//   Avalon-MM edge-capture PIO. It samples in_port every cycle and latches
//   selected edges into edge_capture, which software clears by writing 1s.
//   irq is the OR of the unmasked captured bits.
//
//   Register map (word address):
//     0 data          RO, current sample d_cur
//     1 irq_mask      RW, WIDTH bits
//     2 reserved      reads 0, writes ignored
//     3 edge_capture  read; writing 1 to a bit clears it
//
//   Ports:
//     clk, reset_n           clock; asynchronous active-low reset
//     address, chipselect,
//     write_n, writedata     Avalon-MM slave write/select
//     in_port[WIDTH]         external input pins
//     readdata[32]           registered read data, one-cycle latency
//     irq                    level interrupt
//
//   Parameters: WIDTH (1..32), EDGE_TYPE (0 rise, 1 fall, 2 any),
//               IRQ_MASK_RESET (irq_mask reset value).
//   Build option: define EDGE_PIO_SYNC_EN to place a two-flop synchronizer
//   ahead of d_cur for asynchronous in_port. Without it, in_port must be
//   synchronous to clk.
module nios_system_edge_pio #(
    parameter int               WIDTH          = 32,
    parameter int               EDGE_TYPE      = 0,
    parameter logic [WIDTH-1:0] IRQ_MASK_RESET = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

`ifdef EDGE_PIO_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif

    logic [WIDTH-1:0]     r_cur;
    logic [WIDTH-1:0]     r_prev;
    logic [WIDTH-1:0]     r_mask;
    logic [WIDTH-1:0]     r_cap;
    logic [SYNC_STAGES:0] r_vld_pipe;
    logic                 r_primed;

    logic                 w_wr;
    logic [WIDTH-1:0]     w_sample;
    logic [WIDTH-1:0]     w_edge;
    logic [WIDTH-1:0]     w_clr;
    logic [31:0]          w_rd;

    assign w_wr = chipselect & ~write_n;

    // Input path. r_vld_pipe tracks how far real samples have travelled
    // past the reset zeros: its top bit means d_cur is valid, and one
    // cycle later d_prev is valid too, which is when r_primed is set. This
    // covers the synchronizer depth, so pins that are high at reset release
    // never look like a rising edge.
`ifdef EDGE_PIO_SYNC_EN
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_sync1    <= in_port;
            r_sync2    <= r_sync1;
            r_vld_pipe <= {r_vld_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_sample = r_sync2;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_vld_pipe <= '0;
        else          r_vld_pipe <= 1'b1;
    end

    assign w_sample = in_port;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur    <= '0;
            r_prev   <= '0;
            r_primed <= 1'b0;
        end else begin
            r_cur    <= w_sample;
            r_prev   <= r_cur;
            r_primed <= r_primed | r_vld_pipe[SYNC_STAGES];
        end
    end

    // Edge detection, gated until d_prev holds a real sample.
    always_comb begin
        w_edge = '0;
        if (r_primed) begin
            if (EDGE_TYPE == 0)      w_edge = r_cur & ~r_prev;
            else if (EDGE_TYPE == 1) w_edge = ~r_cur & r_prev;
            else                     w_edge = r_cur ^ r_prev;
        end
    end

    assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A new edge wins over a clear on the same bit, so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cap <= '0;
        else          r_cap <= (r_cap & ~w_clr) | w_edge;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     r_mask <= IRQ_MASK_RESET;
        else if (w_wr && address == 2'd1) r_mask <= writedata[WIDTH-1:0];
    end

    // The read mux ignores chipselect and is registered every cycle.
    always_comb begin
        w_rd = '0;
        case (address)
            2'd0:    w_rd[WIDTH-1:0] = r_cur;
            2'd1:    w_rd[WIDTH-1:0] = r_mask;
            2'd3:    w_rd[WIDTH-1:0] = r_cap;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= w_rd;
    end

    assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_nios_system_edge_pio.sv
// Directed testbench for nios_system_edge_pio. Three instances share one
// bus: a 32-bit rising-edge unit, an 8-bit unit, and a 32-bit any-edge unit.
module tb_nios_system_edge_pio;

`ifdef EDGE_PIO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] in_port = '0;
    logic [31:0] rd_r, rd_8, rd_a;
    logic        irq_r, irq_8, irq_a;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nios_system_edge_pio #(.WIDTH(32), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_r), .irq(irq_r));

    nios_system_edge_pio #(.WIDTH(8), .EDGE_TYPE(0)) dut_w8 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port[7:0]),
        .readdata(rd_8), .irq(irq_8));

    nios_system_edge_pio #(.WIDTH(32), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (LAT + 4) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        in_port = 32'hFFFF_FFFF;
        repeat (3) tick();
        n_chk++;
        if (rd_r !== 32'h0 || irq_r !== 1'b0) begin
            n_err++;
            $display("FAIL in_reset: readdata=%h irq=%b want 00000000/0", rd_r, irq_r);
        end
        reset_n = 1'b1;
        repeat (8) tick();
        bus_read(2'd3);
        n_chk++;
        if (rd_r !== 32'h0) begin
            n_err++;
            $display("FAIL reset_capture: got %h want 00000000", rd_r);
        end
        n_chk++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: rise=%b any=%b want 0/0", irq_r, irq_a);
        end
        n_chk++;
        if (rd_a !== 32'h0) begin
            n_err++;
            $display("FAIL reset_capture_any: got %h want 00000000", rd_a);
        end
        bus_read(2'd1);
        n_chk++;
        if (rd_r !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mask: got %h want 00000000", rd_r);
        end
    endtask

    task automatic test_data_read();
        in_port = 32'hA5A5_0F0F;
        settle();
        bus_write(2'd0, 32'h1234_5678);
        bus_read(2'd0);
        n_chk++;
        if (rd_r !== 32'hA5A5_0F0F) begin
            n_err++;
            $display("FAIL data32: got %h want a5a50f0f", rd_r);
        end
        n_chk++;
        if (rd_8 !== 32'h0000_000F) begin
            n_err++;
            $display("FAIL data8: got %h want 0000000f", rd_8);
        end
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2);
        n_chk++;
        if (rd_r !== 32'h0) begin
            n_err++;
            $display("FAIL reserved: got %h want 00000000", rd_r);
        end
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1);
        n_chk++;
        if (rd_8 !== 32'h0000_00FF || rd_r !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL mask_width: w8=%h w32=%h want 000000ff/ffffffff", rd_8, rd_r);
        end
    endtask

    task automatic test_capture_irq();
        in_port = 32'h0;
        settle();
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'h1);
        in_port = 32'h1;
        settle();
        bus_read(2'd3);
        n_chk++;
        if (rd_r !== 32'h1) begin
            n_err++;
            $display("FAIL capture_bit0: got %h want 00000001", rd_r);
        end
        n_chk++;
        if (irq_r !== 1'b1) begin
            n_err++;
            $display("FAIL irq_set: got %b want 1", irq_r);
        end
        bus_write(2'd3, 32'h1);
        n_chk++;
        if (irq_r !== 1'b0) begin
            n_err++;
            $display("FAIL irq_clear: got %b want 0", irq_r);
        end
    endtask

    task automatic test_mask();
        bus_write(2'd1, 32'h0);
        in_port = 32'h11;
        settle();
        bus_read(2'd3);
        n_chk++;
        if (rd_r !== 32'h10) begin
            n_err++;
            $display("FAIL capture_bit4: got %h want 00000010", rd_r);
        end
        n_chk++;
        if (irq_r !== 1'b0) begin
            n_err++;
            $display("FAIL irq_masked: got %b want 0", irq_r);
        end
        bus_write(2'd1, 32'h10);
        n_chk++;
        if (irq_r !== 1'b1) begin
            n_err++;
            $display("FAIL irq_unmasked: got %b want 1", irq_r);
        end
    endtask

    task automatic test_collision();
        in_port = 32'h0;
        settle();
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3);
        n_chk++;
        if (rd_r !== 32'h0) begin
            n_err++;
            $display("FAIL pre_collision: got %h want 00000000", rd_r);
        end
        in_port = 32'h1;
        repeat (LAT) tick();
        // This write lands on the same edge that sets capture bit 0.
        bus_write(2'd3, 32'h1);
        bus_read(2'd3);
        n_chk++;
        if (rd_r !== 32'h1) begin
            n_err++;
            $display("FAIL collision: got %h want 00000001", rd_r);
        end
    endtask

    task automatic test_any_edge();
        in_port = 32'h0;
        settle();
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'h8);
        in_port = 32'h8;
        settle();
        bus_read(2'd3);
        n_chk++;
        if (rd_a !== 32'h8 || irq_a !== 1'b1) begin
            n_err++;
            $display("FAIL any_rise: cap=%h irq=%b want 00000008/1", rd_a, irq_a);
        end
        bus_write(2'd3, 32'h8);
        n_chk++;
        if (irq_a !== 1'b0) begin
            n_err++;
            $display("FAIL any_clear: got %b want 0", irq_a);
        end
        in_port = 32'h0;
        settle();
        bus_read(2'd3);
        n_chk++;
        if (rd_a !== 32'h8 || irq_a !== 1'b1) begin
            n_err++;
            $display("FAIL any_fall: cap=%h irq=%b want 00000008/1", rd_a, irq_a);
        end
        n_chk++;
        if (rd_r !== 32'h0 || irq_r !== 1'b0) begin
            n_err++;
            $display("FAIL rise_ignores_fall: cap=%h irq=%b want 00000000/0", rd_r, irq_r);
        end
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_capture_irq();
        test_mask();
        test_collision();
        test_any_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
